// File: rtl/wbu_pkg.sv
// Shared types and constants for the write-back unit: FSM states, compare codes,
// branch funct3 encodings, EXU compare modes and the branch resolution helper.
package wbu_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned CNT_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_COMMIT
    } wbu_state_e;

    localparam logic [31:0] CMP_EQ = 32'h0000_0000;
    localparam logic [31:0] CMP_GT = 32'h0000_0002;
    localparam logic [31:0] CMP_LT = 32'h0000_0004;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [3:0] EXU_MODE_CMP_A = 4'b0100;
    localparam logic [3:0] EXU_MODE_CMP_B = 4'b1000;

    typedef struct packed {
        logic taken;
        logic bad;
    } br_res_t;

    // Resolve a branch from its funct3 and the decoded compare code.
    function automatic br_res_t branch_eval(input logic [2:0] funct3, input logic cmp_mode,
                                            input logic eq, input logic gt, input logic lt);
        br_res_t res;
        logic    valid;
        valid     = cmp_mode && (eq || gt || lt);
        res.bad   = !valid;
        res.taken = 1'b0;
        if (valid) begin
            unique case (funct3)
                F3_BEQ:           res.taken = eq;
                F3_BNE:           res.taken = !eq;
                F3_BLT, F3_BLTU:  res.taken = lt;
                F3_BGE, F3_BGEU:  res.taken = !lt;
                default:          res.taken = 1'b0;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/wbu_gpr_file.sv
// 32-entry general-purpose register file: one synchronous write port, two
// asynchronous read ports, x0 hard-wired to zero.
module gpr_file
    import wbu_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [REG_AW-1:0]    waddr_i,
    input  logic [DATAWIDTH-1:0] wdata_i,
    input  logic [REG_AW-1:0]    raddr1_i,
    input  logic [REG_AW-1:0]    raddr2_i,
    output logic [DATAWIDTH-1:0] rdata1_o,
    output logic [DATAWIDTH-1:0] rdata2_o
);

    logic [DATAWIDTH-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/wbu.sv
// Write-back unit: accepts one EXU result at a time, optionally performs a load,
// then commits a register write, the next PC and the retire count in one cycle.
module wbu
    import wbu_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] exu_data,
    input  logic [3:0]           exu_mode,
    input  logic [REG_AW-1:0]    rd,
    input  logic [2:0]           funct3,
    input  logic [DATAWIDTH-1:0] pc,
    input  logic [DATAWIDTH-1:0] imm,
    input  logic                 is_branch,
    input  logic                 is_load,
    input  logic                 reg_wen,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [DATAWIDTH-1:0] mem_addr,
    input  logic                 mem_rsp_valid,
    input  logic [DATAWIDTH-1:0] mem_rsp_data,
    input  logic [REG_AW-1:0]    rf_raddr1,
    input  logic [REG_AW-1:0]    rf_raddr2,
    output logic [DATAWIDTH-1:0] gpr_rdata1,
    output logic [DATAWIDTH-1:0] gpr_rdata2,
    output logic                 npc_valid,
    output logic [DATAWIDTH-1:0] npc,
    output logic [CNT_W-1:0]     retire_cnt,
    output logic                 cmp_err
);

    wbu_state_e           state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic [DATAWIDTH-1:0] ldata_q, ldata_d;
    logic [REG_AW-1:0]    rd_q, rd_d;
    logic                 wen_q, wen_d;
    logic                 ld_q, ld_d;
    logic [DATAWIDTH-1:0] npc_q, npc_d;
    logic                 npc_valid_q, npc_valid_d;
    logic                 mem_req_valid_q, mem_req_valid_d;
    logic [DATAWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]     retire_q, retire_d;
    logic                 cmp_err_q, cmp_err_d;

    logic                 gpr_we_c;
    logic [DATAWIDTH-1:0] gpr_wdata_c;
    br_res_t              br_c;

    // Branch outcome is resolved from the live inputs at acceptance.
    always_comb begin
        br_c = branch_eval(funct3,
                           (exu_mode == EXU_MODE_CMP_A) || (exu_mode == EXU_MODE_CMP_B),
                           exu_data == DATAWIDTH'(CMP_EQ),
                           exu_data == DATAWIDTH'(CMP_GT),
                           exu_data == DATAWIDTH'(CMP_LT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            in_ready_q      <= 1'b1;
            data_q          <= '0;
            ldata_q         <= '0;
            rd_q            <= '0;
            wen_q           <= 1'b0;
            ld_q            <= 1'b0;
            npc_q           <= '0;
            npc_valid_q     <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            retire_q        <= '0;
            cmp_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            in_ready_q      <= in_ready_d;
            data_q          <= data_d;
            ldata_q         <= ldata_d;
            rd_q            <= rd_d;
            wen_q           <= wen_d;
            ld_q            <= ld_d;
            npc_q           <= npc_d;
            npc_valid_q     <= npc_valid_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            retire_q        <= retire_d;
            cmp_err_q       <= cmp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        ldata_d    = ldata_q;
        rd_d       = rd_q;
        wen_d      = wen_q;
        ld_d       = ld_q;
        npc_d      = npc_q;
        mem_addr_d = mem_addr_q;
        retire_d   = retire_q;
        cmp_err_d  = cmp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = exu_data;
                    rd_d    = rd;
                    wen_d   = reg_wen && !is_branch && (rd != '0);
                    ld_d    = is_load;
                    npc_d   = (is_branch && br_c.taken) ? pc + imm : pc + DATAWIDTH'(4);
                    if (is_branch && br_c.bad) begin
                        cmp_err_d = 1'b1;
                    end
                    if (is_load) begin
                        mem_addr_d = exu_data;
                        state_d    = ST_MEM_REQ;
                    end else begin
                        state_d    = ST_COMMIT;
                    end
                end
            end
            ST_MEM_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_rsp_valid) begin
                    ldata_d = mem_rsp_data;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                retire_d = retire_q + CNT_W'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes follow the state being entered so they line up with it.
        in_ready_d      = (state_d == ST_IDLE);
        npc_valid_d     = (state_d == ST_COMMIT);
        mem_req_valid_d = (state_d == ST_MEM_REQ);
    end

    assign gpr_we_c    = (state_q == ST_COMMIT) && wen_q;
    assign gpr_wdata_c = ld_q ? ldata_q : data_q;

    gpr_file #(.DATAWIDTH(DATAWIDTH)) u_gpr_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (gpr_we_c),
        .waddr_i  (rd_q),
        .wdata_i  (gpr_wdata_c),
        .raddr1_i (rf_raddr1),
        .raddr2_i (rf_raddr2),
        .rdata1_o (gpr_rdata1),
        .rdata2_o (gpr_rdata2)
    );

    assign in_ready      = in_ready_q;
    assign npc_valid     = npc_valid_q;
    assign npc           = npc_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign retire_cnt    = retire_q;
    assign cmp_err       = cmp_err_q;

endmodule

// File: tb/tb_wbu.sv
// Self-checking bench for wbu: directed scenarios plus randomized instructions
// checked against an architectural model (register array, retire count, error flag).
module tb_wbu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] exu_data;
    logic [3:0]  exu_mode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        is_branch;
    logic        is_load;
    logic        reg_wen;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] gpr_rdata1;
    logic [31:0] gpr_rdata2;
    logic        npc_valid;
    logic [31:0] npc;
    logic [31:0] retire_cnt;
    logic        cmp_err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_retire;
    logic        m_cmp_err;

    always #5 clk = ~clk;

    wbu #(.DATAWIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .exu_data      (exu_data),
        .exu_mode      (exu_mode),
        .rd            (rd),
        .funct3        (funct3),
        .pc            (pc),
        .imm           (imm),
        .is_branch     (is_branch),
        .is_load       (is_load),
        .reg_wen       (reg_wen),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr2     (rf_raddr2),
        .gpr_rdata1    (gpr_rdata1),
        .gpr_rdata2    (gpr_rdata2),
        .npc_valid     (npc_valid),
        .npc           (npc),
        .retire_cnt    (retire_cnt),
        .cmp_err       (cmp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_retire  = 32'h0;
        m_cmp_err = 1'b0;
    endtask

    // Architectural branch rule: valid compare code and mode, then funct3 decides.
    function automatic logic m_taken(input logic [2:0] f3, input logic [3:0] mode,
                                     input logic [31:0] code, output logic bad);
        logic ok;
        ok  = (mode == 4'b0100 || mode == 4'b1000) && (code == 0 || code == 2 || code == 4);
        bad = !ok;
        if (!ok) return 1'b0;
        case (f3)
            3'd0:       return code == 0;
            3'd1:       return code != 0;
            3'd4, 3'd6: return code == 4;
            3'd5, 3'd7: return code != 4;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic scramble_inputs();
        exu_data  = $urandom;
        exu_mode  = 4'($urandom);
        rd        = 5'($urandom);
        funct3    = 3'($urandom);
        pc        = $urandom;
        imm       = $urandom;
        is_branch = 1'($urandom);
        is_load   = 1'($urandom);
        reg_wen   = 1'($urandom);
    endtask

    // Issue one instruction from IDLE and follow it through COMMIT; starts and ends at posedge+1.
    task automatic issue(input logic [31:0] data, input logic [3:0] mode, input logic [4:0] r,
                         input logic [2:0] f3, input logic [31:0] ipc, input logic [31:0] iimm,
                         input logic br, input logic ld, input logic wen,
                         input logic [31:0] ldata, input int req_wait, input int rsp_wait);
        logic        tk, bad;
        logic [31:0] exp_npc;
        logic [4:0]  other;
        tk      = br ? m_taken(f3, mode, data, bad) : 1'b0;
        if (!br) bad = 1'b0;
        exp_npc = tk ? ipc + iimm : ipc + 32'd4;
        if (bad) m_cmp_err = 1'b1;

        check("in_ready_idle", 32'(in_ready), 32'd1);
        exu_data = data; exu_mode = mode; rd = r; funct3 = f3; pc = ipc; imm = iimm;
        is_branch = br; is_load = ld; reg_wen = wen; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        scramble_inputs();
        if (ld) begin
            for (int i = 0; i <= req_wait; i++) begin
                check("mem_req_valid", 32'(mem_req_valid), 32'd1);
                check("mem_addr_held", mem_addr, data);
                check("in_ready_busy", 32'(in_ready), 32'd0);
                mem_req_ready = (i == req_wait);
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = $urandom;
                step();
            end
            mem_req_ready = 1'b0;
            for (int j = 0; j <= rsp_wait; j++) begin
                check("mem_req_dropped", 32'(mem_req_valid), 32'd0);
                mem_rsp_valid = (j == rsp_wait);
                mem_rsp_data  = (j == rsp_wait) ? ldata : $urandom;
                step();
            end
            mem_rsp_valid = 1'b0;
        end
        check("npc_valid_commit", 32'(npc_valid), 32'd1);
        check("npc_value", npc, exp_npc);
        check("cmp_err_commit", 32'(cmp_err), 32'(m_cmp_err));
        if (wen && !br && r != 5'd0) m_regs[r] = ld ? ldata : data;
        m_retire = m_retire + 32'd1;
        step();
        check("npc_valid_drop", 32'(npc_valid), 32'd0);
        check("retire_cnt", retire_cnt, m_retire);
        check("in_ready_back", 32'(in_ready), 32'd1);
        other     = 5'($urandom);
        rf_raddr1 = r;
        rf_raddr2 = other;
        #1;
        check("rd_read", gpr_rdata1, m_regs[r]);
        check("rand_read", gpr_rdata2, m_regs[other]);
    endtask

    task automatic reset_mid_load(input logic [4:0] r);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        exu_data = 32'h8000_0040; exu_mode = 4'd0; rd = r; funct3 = 3'd2; pc = 32'h200; imm = 32'h0;
        is_branch = 1'b0; is_load = 1'b1; reg_wen = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        check("mem_wait_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #2;
        check("rst_npc_valid", 32'(npc_valid), 32'd0);
        check("rst_retire", retire_cnt, 32'd0);
        check("rst_mem_req", 32'(mem_req_valid), 32'd0);
        check("rst_cmp_err", 32'(cmp_err), 32'd0);
        model_reset();
        step();
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hCAFE_F00D;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        step();
        mem_rsp_valid = 1'b0;
        check("rel_no_npc", 32'(npc_valid), 32'd0);
        check("rel_retire", retire_cnt, 32'd0);
        check("rel_in_ready2", 32'(in_ready), 32'd1);
        rf_raddr1 = r;
        #1;
        check("rel_no_write", gpr_rdata1, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rsp_data = 32'h0; rf_raddr1 = 5'd5; rf_raddr2 = 5'd31;
        exu_data = 32'h0; exu_mode = 4'h0; rd = 5'h0; funct3 = 3'h0; pc = 32'h0; imm = 32'h0;
        is_branch = 1'b0; is_load = 1'b0; reg_wen = 1'b0;
        model_reset();
        repeat (3) step();
        check("rst_npc_valid", 32'(npc_valid), 32'd0);
        check("rst_npc", npc, 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_retire_cnt", retire_cnt, 32'd0);
        check("rst_cmp_err", 32'(cmp_err), 32'd0);
        check("rst_reg5", gpr_rdata1, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        step();

        issue(32'h1234, 4'd0, 5'd5, 3'd0, 32'h1000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 0, 0);
        issue(32'h8000_0010, 4'd0, 5'd9, 3'd2, 32'h1004, 32'h0, 1'b0, 1'b1, 1'b1,
              32'hDEAD_BEEF, 3, 2);
        issue(32'd0, 4'b0100, 5'd7, 3'b000, 32'h100, 32'h20, 1'b1, 1'b0, 1'b1, 32'h0, 0, 0);
        issue(32'd0, 4'b0100, 5'd7, 3'b001, 32'h100, 32'h20, 1'b1, 1'b0, 1'b1, 32'h0, 0, 0);
        issue(32'd4, 4'b1000, 5'd7, 3'b101, 32'h100, 32'h20, 1'b1, 1'b0, 1'b1, 32'h0, 0, 0);
        issue(32'd4, 4'b0100, 5'd7, 3'b110, 32'h100, 32'h20, 1'b1, 1'b0, 1'b1, 32'h0, 0, 0);
        issue(32'hFFFF_FFFF, 4'd0, 5'd0, 3'd0, 32'h300, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 0, 0);
        issue(32'd6, 4'b0100, 5'd3, 3'b000, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
        issue(32'd2, 4'b0010, 5'd3, 3'b001, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);

        reset_mid_load(5'd5);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] d;
            logic [3:0]  md;
            int unsigned kind;
            kind = $urandom_range(0, 2);
            md   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (($urandom_range(0, 1) == 0) ? 4'b0100 : 4'b1000);
            case ($urandom_range(0, 4))
                0: d = 32'd0;
                1: d = 32'd2;
                2: d = 32'd4;
                3: d = 32'($urandom_range(0, 7));
                default: d = $urandom;
            endcase
            issue(d, md, 5'($urandom), 3'($urandom), $urandom, $urandom,
                  kind == 1, kind == 2, 1'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wbu.md
WBU -- requirements
Module: wbu

Interface
REQ-001 Parameter DATAWIDTH, default 32: width of data, PC and register file entries.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid/in_ready  input/output  1/1  instruction handshake from EXU.
REQ-005 exu_data  input  32  EXU result, load address, or compare code.
REQ-006 exu_mode  input  4  EXU mode; 4'b0100 and 4'b1000 are compare modes.
REQ-007 rd/funct3  input  5/3  destination register and instruction funct3.
REQ-008 pc/imm  input  32/32  instruction PC and immediate.
REQ-009 is_branch/is_load/reg_wen  input  1 each  instruction class and write enable.
REQ-010 mem_req_valid/mem_req_ready  output/input  1/1  load request handshake.
REQ-011 mem_addr  output  32  load address.
REQ-012 mem_rsp_valid/mem_rsp_data  input  1/32  load response.
REQ-013 rf_raddr1/rf_raddr2  input  5/5  register read addresses from IDU.
REQ-014 gpr_rdata1/gpr_rdata2  output  32/32  combinational register read data to EXU.
REQ-015 npc_valid/npc  output  1/32  one-cycle next-PC strobe and value.
REQ-016 retire_cnt  output  32  count of committed instructions.
REQ-017 cmp_err  output  1  sticky flag for an invalid compare code.

Function
REQ-018 The FSM SHALL have states IDLE, MEM_REQ, MEM_WAIT and COMMIT; in_ready SHALL be 1 only in IDLE.
REQ-019 On in_valid&&in_ready, all inputs SHALL be latched; next state COMMIT if !is_load, else MEM_REQ.
REQ-020 In MEM_REQ: mem_req_valid=1, mem_addr=latched exu_data, held stable until mem_req_ready; then go to MEM_WAIT.
REQ-021 In MEM_WAIT, the first mem_rsp_valid SHALL capture mem_rsp_data and go to COMMIT; a response in MEM_REQ SHALL be ignored.
REQ-022 COMMIT SHALL last exactly one cycle, assert npc_valid, increment retire_cnt (wraps at 2^32-1 to 0), then return to IDLE.
REQ-023 Non-load latency: npc_valid SHALL be asserted in the cycle immediately after acceptance.
REQ-024 Register write in COMMIT only if reg_wen && !is_branch && rd!=0; data = load data if is_load, else exu_data.
REQ-025 Compare codes: 0 = equal, 32'b10 = greater, 32'b100 = less.
REQ-026 Taken rules: beq(000) code==0; bne(001) code!=0; blt/bltu(100/110) code==4; bge/bgeu(101/111) code!=4; other funct3 not taken.
REQ-027 A branch whose exu_mode is not a compare mode, or whose code is not in {0,2,4}, SHALL be not taken and SHALL set cmp_err.
REQ-028 npc = pc+imm if taken, else pc+4, modulo 2^32.
REQ-029 Register reads SHALL be combinational; x0 SHALL read 0; a COMMIT write is visible from the next cycle (no bypass).

Reset
REQ-030 While rst_n=0: FSM=IDLE, all 32 registers=0, and npc_valid, npc, mem_req_valid, mem_addr, retire_cnt and cmp_err = 0.
REQ-031 Reset mid-operation SHALL abandon the instruction: no register write, no npc_valid, no retire increment.
REQ-032 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the compare-code constants CMP_EQ/CMP_GT/CMP_LT, the branch funct3 constants, and the EXU compare-mode constants.
REQ-034 The register file SHALL be a sub-module gpr_file: 32xDATAWIDTH, one write port, two async read ports.

Verification
REQ-035 Add: exu_data=0x1234, rd=5, reg_wen=1 -> next cycle npc_valid, npc=pc+4; following cycle rf_raddr1=5 reads 0x1234.
REQ-036 Load: exu_data=0x80000010; mem_req_ready low 3 cycles, response 0xDEADBEEF 2 cycles later -> mem_addr held at 0x80000010; rd reads 0xDEADBEEF after COMMIT.
REQ-037 Branches: pc=0x100, imm=0x20; beq code 0 -> npc 0x120; bne code 0 -> npc 0x104; bge code 4 -> npc 0x104; bltu code 4 -> npc 0x120.
REQ-038 rd=0, reg_wen=1, exu_data=0xFFFFFFFF -> x0 still reads 0; beq with code 6 -> not taken, cmp_err=1.
REQ-039 rst_n pulsed low during MEM_WAIT -> no write, retire_cnt=0, state IDLE, in_ready=1 after release.
